uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO. It is the successor to the fixed 8N1 transmitter used by the CPU UART path. It adds configurable data width, stop-bit count and optional parity, and buffers bursts so that producers (CPU, testbench stimulus) can queue several characters without polling for completion. Frames go out back-to-back with no idle gap while the FIFO is non-empty.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_tx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, parity mode constants and parity helper for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // The payload is zero-extended to 9 bits; zero padding does not change the XOR.
  function automatic logic calc_parity(input logic [8:0] payload, input int mode);
    return (^payload) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with show-ahead read data and level output.
// Pointers carry one extra wrap bit so that full and empty remain distinguishable.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, configurable width/stop bits, back-to-back frames.
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_tx,
  output logic                          out_busy,
  output logic                          out_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_overflow
);

  // Handshake: a write is taken on any rising edge with in_valid && in_ready;
  // in_ready is the registered FIFO state (!full) and ignores a same-cycle pop.

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ACTIVE = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  logic par_bit;
`else
  // Without the generator the parity setting is accepted but has no effect.
  localparam logic PAR_ACTIVE = 1'b0 && (PARITY != PAR_NONE);
`endif

  tx_state_t            state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 push;
  logic                 pop;
  logic                 baud_end;
  logic                 frame_end;

  assign in_ready  = ~fifo_full;
  assign push      = in_valid & ~fifo_full;
  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);
  // The head word leaves the FIFO when a frame starts from idle or chains off a finished one.
  assign pop       = ~fifo_empty & ((state == IDLE) | frame_end);
  assign out_busy  = (state != IDLE);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
    end else if (pop) begin
      par_bit <= calc_parity(9'(fifo_rdata), PARITY);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      out_tx       <= 1'b1;
      out_done     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      out_done     <= 1'b0;
      err_overflow <= in_valid & fifo_full;

      if (state == IDLE || baud_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (pop) begin
        shreg <= fifo_rdata;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state  <= START;
            out_tx <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            out_tx  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PAR_ACTIVE) begin
`ifdef UART_TX_PARITY_EN
                state  <= uart_pkg::PARITY;
                out_tx <= par_bit;
`endif
              end else begin
                state  <= STOP;
                out_tx <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              out_tx  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        uart_pkg::PARITY: begin
          if (baud_end) begin
            state  <= STOP;
            out_tx <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            if (bit_cnt == STOP_LAST) begin
              out_done <= 1'b1;
              bit_cnt  <= '0;
              if (pop) begin
                state  <= START;
                out_tx <= 1'b0;
              end else begin
                state  <= IDLE;
                out_tx <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          out_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with hand-computed line frames.
// Frame vectors hold line bits in time order: bit 0 is the start bit.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_NB = 11;
  localparam logic [15:0] EXP_EVEN = {5'b0, 2'b11, 1'b1, 7'h07, 1'b0};
  localparam logic [15:0] EXP_ODD  = {5'b0, 2'b11, 1'b0, 7'h07, 1'b0};
`else
  localparam int PAR_NB = 10;
  localparam logic [15:0] EXP_EVEN = {6'b0, 2'b11, 7'h07, 1'b0};
  localparam logic [15:0] EXP_ODD  = {6'b0, 2'b11, 7'h07, 1'b0};
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 8N1, 16-deep; DUT B: 8N1, 4-deep; DUT C/D: 7 data, 2 stop, even/odd parity
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy, a_done, a_ovf;
  logic [4:0] a_level;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy, b_done, b_ovf;
  logic [2:0] b_level;
  logic [6:0] c_data = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_tx, c_busy, c_done, c_ovf;
  logic [4:0] c_level;
  logic [6:0] d_data = '0;
  logic       d_valid = 1'b0;
  logic       d_ready, d_tx, d_busy, d_done, d_ovf;
  logic [4:0] d_level;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_tx(a_tx), .out_busy(a_busy), .out_done(a_done), .fifo_level(a_level), .err_overflow(a_ovf));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_tx(b_tx), .out_busy(b_busy), .out_done(b_done), .fifo_level(b_level), .err_overflow(b_ovf));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16), .PARITY(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_tx(c_tx), .out_busy(c_busy), .out_done(c_done), .fifo_level(c_level), .err_overflow(c_ovf));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16), .PARITY(2)) u_d (
    .clk(clk), .rst_n(rst_n), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
    .out_tx(d_tx), .out_busy(d_busy), .out_done(d_done), .fifo_level(d_level), .err_overflow(d_ovf));

  // observation mux: which DUT the line monitor follows
  int sel = 0;
  logic       tx_obs, done_obs, busy_obs;
  logic [4:0] level_obs;
  always_comb begin
    case (sel)
      0:       begin tx_obs = a_tx; done_obs = a_done; busy_obs = a_busy; level_obs = a_level; end
      1:       begin tx_obs = b_tx; done_obs = b_done; busy_obs = b_busy; level_obs = 5'(b_level); end
      2:       begin tx_obs = c_tx; done_obs = c_done; busy_obs = c_busy; level_obs = c_level; end
      default: begin tx_obs = d_tx; done_obs = d_done; busy_obs = d_busy; level_obs = d_level; end
    endcase
  end

  int done_q[$];
  int busy_cnt = 0;
  int hold_err = 0;
  always @(negedge clk) begin
    if (done_obs === 1'b1) done_q.push_back(cyc);
    if (busy_obs === 1'b1) busy_cnt++;
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_in(input int s, input logic [8:0] w, input logic v);
    case (s)
      0:       begin a_data = w[7:0]; a_valid = v; end
      1:       begin b_data = w[7:0]; b_valid = v; end
      2:       begin c_data = w[6:0]; c_valid = v; end
      default: begin d_data = w[6:0]; d_valid = v; end
    endcase
  endtask

  // Call at a falling edge; returns at the falling edge after the last bit.
  task automatic capture(input int nbits, output logic [15:0] bits, output int fall_cyc);
    int budget;
    logic b;
    bits = '0;
    budget = 0;
    fall_cyc = -1;
    while (tx_obs !== 1'b0 && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    chk("frame_start", 32'(tx_obs), 0);
    if (tx_obs !== 1'b0) return;
    fall_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      b = tx_obs;
      for (int c = 0; c < CPB; c++) begin
        if (c == 0) bits[i] = tx_obs;
        else if (tx_obs !== b) hold_err++;
        @(negedge clk);
      end
    end
  endtask

  task automatic frame_test(input int s, input logic [8:0] w, input int nb,
                            input logic [15:0] exp, input string tag);
    logic [15:0] bits;
    int f;
    int d;
    sel = s;
    done_q.delete();
    busy_cnt = 0;
    hold_err = 0;
    @(negedge clk);
    set_in(s, w, 1'b1);
    fork
      begin
        @(negedge clk);
        set_in(s, w, 1'b0);
        chk({tag, "_lvl_after_write"}, 32'(level_obs), 1);
        chk({tag, "_tx_still_idle"}, 32'(tx_obs), 1);
        @(negedge clk);
        chk({tag, "_lvl_after_pop"}, 32'(level_obs), 0);
        chk({tag, "_tx_start"}, 32'(tx_obs), 0);
      end
      begin
        capture(nb, bits, f);
      end
    join
    chk({tag, "_bits"}, 32'(bits), 32'(exp));
    repeat (3) @(negedge clk);
    #1;
    d = (done_q.size() > 0) ? done_q[0] : -1;
    chk({tag, "_done_count"}, done_q.size(), 1);
    chk({tag, "_done_latency"}, d - f, nb * CPB);
    chk({tag, "_busy_cycles"}, busy_cnt, nb * CPB);
    chk({tag, "_bit_hold"}, hold_err, 0);
    chk({tag, "_idle_tx"}, 32'(tx_obs), 1);
  endtask

  task automatic burst_test();
    logic [15:0] bits[3];
    int f[3];
    sel = 0;
    done_q.delete();
    busy_cnt = 0;
    hold_err = 0;
    exp_q.push_back({6'b0, 1'b1, 8'h46, 1'b0});
    exp_q.push_back({6'b0, 1'b1, 8'h49, 1'b0});
    exp_q.push_back({6'b0, 1'b1, 8'h0A, 1'b0});
    @(negedge clk);
    set_in(0, 9'h46, 1'b1);
    fork
      begin
        @(negedge clk); set_in(0, 9'h49, 1'b1);
        @(negedge clk); set_in(0, 9'h0A, 1'b1);
        @(negedge clk); set_in(0, 9'h00, 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) capture(10, bits[i], f[i]);
      end
    join
    for (int i = 0; i < 3; i++) chk("burst_frame", 32'(bits[i]), 32'(exp_q.pop_front()));
    chk("burst_gap_1", f[1] - f[0], 40);
    chk("burst_gap_2", f[2] - f[1], 40);
    repeat (3) @(negedge clk);
    #1;
    chk("burst_done_count", done_q.size(), 3);
    if (done_q.size() == 3) begin
      chk("burst_done_first", done_q[0] - f[0], 40);
      chk("burst_done_span", done_q[2] - done_q[0], 80);
    end
    chk("burst_busy_cycles", busy_cnt, 120);
    chk("burst_bit_hold", hold_err, 0);
  endtask

  task automatic overflow_test();
    logic [7:0] w[6];
    logic [15:0] bits;
    int f;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sel = 1;
    done_q.delete();
    hold_err = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back({6'b0, 1'b1, w[i], 1'b0});
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          set_in(1, {1'b0, w[i]}, 1'b1);
          @(negedge clk);
          if (i == 4) begin
            chk("ovf_no_pulse_yet", 32'(b_ovf), 0);
            chk("ovf_level_full", 32'(b_level), 4);
            chk("ovf_ready_low", 32'(b_ready), 0);
          end
        end
        chk("ovf_pulse", 32'(b_ovf), 1);
        chk("ovf_level_held", 32'(b_level), 4);
        chk("ovf_ready_still_low", 32'(b_ready), 0);
        set_in(1, 9'h0, 1'b0);
        @(negedge clk);
        chk("ovf_pulse_one_cycle", 32'(b_ovf), 0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          capture(10, bits, f);
          chk("ovf_frame", 32'(bits), 32'(exp_q.pop_front()));
        end
      end
    join
    repeat (3) @(negedge clk);
    #1;
    chk("ovf_done_count", done_q.size(), 5);
    chk("ovf_level_drained", 32'(b_level), 0);
    chk("ovf_bit_hold", hold_err, 0);
  endtask

  task automatic reset_mid_test();
    int low_cnt;
    sel = 0;
    @(negedge clk); set_in(0, 9'h46, 1'b1);
    @(negedge clk); set_in(0, 9'h49, 1'b1);
    @(negedge clk); set_in(0, 9'h0A, 1'b1);
    @(negedge clk); set_in(0, 9'h00, 1'b0);
    repeat (16) @(negedge clk);
    chk("rst_pre_level", 32'(a_level), 2);
    chk("rst_pre_tx_bit3", 32'(a_tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(a_tx), 1);
    chk("rst_flush_level", 32'(a_level), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_ready", 32'(a_ready), 1);
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_tx !== 1'b1) low_cnt++;
    end
    #1;
    chk("rst_line_stays_high", low_cnt, 0);
    chk("rst_no_done", done_q.size(), 0);
    chk("rst_level_after", 32'(a_level), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hold_tx", 32'(a_tx), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tx", 32'(a_tx), 1);
    chk("reset_ready", 32'(a_ready), 1);
    chk("reset_level", 32'(a_level), 0);
    chk("reset_busy", 32'(a_busy), 0);
    chk("reset_done", 32'(a_done), 0);
    chk("reset_ovf", 32'(a_ovf), 0);

    frame_test(0, 9'h46, 10, 16'h028C, "single");
    burst_test();
    overflow_test();
    frame_test(2, 9'h07, PAR_NB, EXP_EVEN, "par_even");
    frame_test(3, 9'h07, PAR_NB, EXP_ODD, "par_odd");
    reset_mid_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
